wb_port_arbiter: RTL and testbench

//  Shares the single register-file write port between the in-order pipeline writeback stage
//  and a long-latency unit (LL: mul/div, late load return).
//  - Pipeline writes pass straight through and have priority.
//  - LL results queue in a small FIFO and drain into idle port cycles.
//  - A starvation counter stalls the pipeline for one cycle to force a drain.
//  - Stale LL results are squashed by younger pipeline writes to the same rd.

---
 rtl/core_pkg.sv | 22 ++
 rtl/wb_kill_fifo.sv | 54 +++++
 rtl/wb_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_wb_port_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared write-back definitions: register address width, write-back entry
// layout and the port-arbiter state encoding.
package core_pkg;

  localparam int REG_AW    = 5;
  localparam int WB_DWIDTH = 32;

  // One queued long-latency result; kill marks it as superseded by a younger
  // pipeline write to the same destination register.
  typedef struct packed {
    logic                 kill;
    logic [REG_AW-1:0]    rd;
    logic [WB_DWIDTH-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    WBA_IDLE,
    WBA_DRAIN,
    WBA_FORCE
  } wbarb_state_e;

endpackage

// File: rtl/wb_kill_fifo.sv
// Small circular FIFO of write-back entries. Besides push/pop it can mark
// every stored entry whose rd matches kill_rd as killed, all in one cycle.
module wb_kill_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  wb_entry_t         push_entry,
  input  logic              pop,
  input  logic              kill_en,
  input  logic [REG_AW-1:0] kill_rd,
  output wb_entry_t         head,
  output logic [CW-1:0]     count
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  // Entry storage: parallel kill marking, then the push write. A same-cycle
  // push carries its own kill bit, so writing it last is correct.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && (mem[i].rd == kill_rd)) mem[i].kill <= 1'b1;
      end
      if (push) mem[wr_ptr] <= push_entry;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; occupancy count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the pipeline writeback stage and
// the long-latency unit. Pipeline writes pass through with priority; LL results
// queue and drain into idle port cycles, with a forced one-cycle pipeline stall
// when the queue head has been blocked for too long.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  WBA_IDLE  | FIFO empty, nothing waiting
//  WBA_DRAIN | FIFO non-empty, head drains into idle port cycles
//  WBA_FORCE | one-cycle stall of the pipeline to pop the starved head
module wb_port_arbiter
  import core_pkg::*;
#(
  parameter int DWIDTH   = WB_DWIDTH,
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pipe_we_i,
  input  logic [REG_AW-1:0]          pipe_rd_i,
  input  logic [DWIDTH-1:0]          pipe_data_i,
  input  logic                       ll_valid_i,
  output logic                       ll_ready_o,
  input  logic [REG_AW-1:0]          ll_rd_i,
  input  logic [DWIDTH-1:0]          ll_data_i,
  output logic                       rf_we_o,
  output logic [REG_AW-1:0]          rf_rd_o,
  output logic [DWIDTH-1:0]          rf_data_o,
  output logic                       stall_o,
  output logic [$clog2(DEPTH+1)-1:0] fifo_cnt_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);

  wbarb_state_e      state_q, state_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic [CW-1:0]     count, cnt_nxt;
  wb_entry_t         head, push_entry;
  logic              push, pop, kill_en, pipe_act, fifo_empty, has_room;
  logic              rf_we_c, stall_c;
  logic [REG_AW-1:0] rf_rd_c;
  logic [DWIDTH-1:0] rf_data_c;

  assign fifo_empty = (count == '0);
  assign has_room   = (count < CW'(DEPTH));
  assign pipe_act   = pipe_we_i && (pipe_rd_i != '0);
  // x0 results are acknowledged but dropped.
  assign push       = ll_valid_i && has_room && (ll_rd_i != '0);
  assign cnt_nxt    = count + CW'(push) - CW'(pop);

  always_comb begin
    push_entry      = '0;
    push_entry.kill = kill_en && (ll_rd_i == pipe_rd_i);
    push_entry.rd   = ll_rd_i;
    push_entry.data = ll_data_i;
  end

  wb_kill_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .kill_en    (kill_en),
    .kill_rd    (pipe_rd_i),
    .head       (head),
    .count      (count)
  );

  // Per-cycle port decision: forced drain, then pipeline, then idle-slot drain.
  always_comb begin
    rf_we_c   = 1'b0;
    rf_rd_c   = '0;
    rf_data_c = '0;
    stall_c   = 1'b0;
    pop       = 1'b0;
    kill_en   = 1'b0;
    if (state_q == WBA_FORCE) begin
      stall_c = 1'b1;
      pop     = !fifo_empty;
      rf_we_c = !fifo_empty && !head.kill;
    end else if (pipe_act) begin
      rf_we_c   = 1'b1;
      rf_rd_c   = pipe_rd_i;
      rf_data_c = pipe_data_i;
      kill_en   = 1'b1;
      // A killed head costs no port cycle, so retire it behind the pipe write.
      pop       = !fifo_empty && head.kill;
    end else if (!fifo_empty) begin
      pop     = 1'b1;
      rf_we_c = !head.kill;
    end
    if (rf_we_c && !pipe_act) begin
      rf_rd_c   = head.rd;
      rf_data_c = head.data;
    end
    if (state_q == WBA_FORCE && rf_we_c) begin
      rf_rd_c   = head.rd;
      rf_data_c = head.data;
    end
  end

  // Next-state and starvation counter. FORCE is entered in the same cycle the
  // counter reaches MAX_WAIT, so the stall lands MAX_WAIT+1 cycles after push.
  always_comb begin
    wait_d  = '0;
    state_d = (cnt_nxt != '0) ? WBA_DRAIN : WBA_IDLE;
    case (state_q)
      WBA_DRAIN: begin
        if (!pop && !fifo_empty) begin
          wait_d = wait_q + 1'b1;
          if (wait_d == WW'(MAX_WAIT)) state_d = WBA_FORCE;
        end
      end
      default: wait_d = '0;
    endcase
  end

  // FSM state and wait counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= WBA_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Outputs are held quiet while reset is asserted, including pass-through.
  assign rf_we_o    = reset && rf_we_c;
  assign rf_rd_o    = reset ? rf_rd_c : '0;
  assign rf_data_o  = reset ? rf_data_c : '0;
  assign stall_o    = reset && stall_c;
  assign ll_ready_o = reset && has_room;
  assign fifo_cnt_o = count;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: pass-through, idle-slot drain,
// starvation stall, squash, back-pressure and mid-stall reset.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_we_i;
  logic [4:0]  pipe_rd_i;
  logic [31:0] pipe_data_i;
  logic        ll_valid_i;
  logic        ll_ready_o;
  logic [4:0]  ll_rd_i;
  logic [31:0] ll_data_i;
  logic        rf_we_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_data_o;
  logic        stall_o;
  logic [2:0]  fifo_cnt_o;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] rf_model [32];
  logic [4:0]  ll_log [$];
  logic        log_en = 1'b0;

  wb_port_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .pipe_we_i   (pipe_we_i),
    .pipe_rd_i   (pipe_rd_i),
    .pipe_data_i (pipe_data_i),
    .ll_valid_i  (ll_valid_i),
    .ll_ready_o  (ll_ready_o),
    .ll_rd_i     (ll_rd_i),
    .ll_data_i   (ll_data_i),
    .rf_we_o     (rf_we_o),
    .rf_rd_o     (rf_rd_o),
    .rf_data_o   (rf_data_o),
    .stall_o     (stall_o),
    .fifo_cnt_o  (fifo_cnt_o)
  );

  always #5 clk = ~clk;

  // Register-file model and LL write log, sampled mid-cycle.
  always @(negedge clk) begin
    #2;
    if (rf_we_o) begin
      rf_model[rf_rd_o] = rf_data_o;
      if (log_en && rf_rd_o != 5'd3) ll_log.push_back(rf_rd_o);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle's drive point.
  task automatic next_cyc();
    @(negedge clk);
  endtask

  task automatic set_pipe(input logic we, input logic [4:0] rd, input logic [31:0] d);
    pipe_we_i = we; pipe_rd_i = rd; pipe_data_i = d;
  endtask

  task automatic set_ll(input logic v, input logic [4:0] rd, input logic [31:0] d);
    ll_valid_i = v; ll_rd_i = rd; ll_data_i = d;
  endtask

  initial begin
    int i;
    logic rdy;
    for (int r = 0; r < 32; r++) rf_model[r] = '0;
    reset = 1'b0;
    set_pipe(1'b1, 5'd5, 32'hA5);
    set_ll(1'b1, 5'd6, 32'h66);

    // Reset: outputs quiet even with requests present.
    next_cyc(); #1;
    check("rst_rf_we", rf_we_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_ready", ll_ready_o, 0);
    check("rst_cnt", fifo_cnt_o, 0);
    set_ll(1'b0, 5'd0, 32'h0);
    set_pipe(1'b0, 5'd0, 32'h0);
    next_cyc();
    reset = 1'b1;

    // 1. Pipe-only pass-through.
    for (int k = 0; k < 4; k++) begin
      next_cyc();
      set_pipe(1'b1, 5'd5, 32'hA5);
      #1;
      check("t1_we", rf_we_o, 1);
      check("t1_rd", rf_rd_o, 5);
      check("t1_data", rf_data_o, 32'hA5);
      check("t1_stall", stall_o, 0);
    end

    // 2. LL into idle port, one cycle after handshake.
    next_cyc();
    set_pipe(1'b0, 5'd0, 32'h0);
    set_ll(1'b1, 5'd7, 32'h1234);
    #1;
    check("t2_ready", ll_ready_o, 1);
    check("t2_nobypass", rf_we_o, 0);
    next_cyc();
    set_ll(1'b0, 5'd0, 32'h0);
    #1;
    check("t2_we", rf_we_o, 1);
    check("t2_rd", rf_rd_o, 7);
    check("t2_data", rf_data_o, 32'h1234);
    check("t2_cnt1", fifo_cnt_o, 1);
    next_cyc(); #1;
    check("t2_cnt0", fifo_cnt_o, 0);
    check("t2_idle", rf_we_o, 0);

    // 3. Starvation: forced drain MAX_WAIT+1 cycles after push.
    next_cyc();
    set_pipe(1'b1, 5'd3, 32'h33);
    set_ll(1'b1, 5'd9, 32'h99);
    for (int k = 1; k <= 11; k++) begin
      next_cyc();
      set_ll(1'b0, 5'd0, 32'h0);
      #1;
      check($sformatf("t3_stall_k%0d", k), stall_o, (k == 9) ? 1 : 0);
      check($sformatf("t3_rd_k%0d", k), rf_rd_o, (k == 9) ? 9 : 3);
      if (k == 9) check("t3_data", rf_data_o, 32'h99);
      if (k == 10) check("t3_cnt", fifo_cnt_o, 0);
    end

    // 4a. Squash by a later pipe write to the same rd.
    next_cyc();
    set_ll(1'b1, 5'd4, 32'h11);
    next_cyc();
    set_ll(1'b0, 5'd0, 32'h0);
    set_pipe(1'b1, 5'd4, 32'h22);
    #1;
    check("t4a_pipe_rd", rf_rd_o, 4);
    check("t4a_cnt1", fifo_cnt_o, 1);
    next_cyc();
    set_pipe(1'b0, 5'd0, 32'h0);
    #1;
    check("t4a_killed_we", rf_we_o, 0);
    next_cyc(); #1;
    check("t4a_cnt0", fifo_cnt_o, 0);
    check("t4a_x4", rf_model[4], 32'h22);

    // 4b. Same-cycle push and pipe write to rd=4.
    set_pipe(1'b1, 5'd4, 32'h22);
    set_ll(1'b1, 5'd4, 32'h11);
    next_cyc();
    set_pipe(1'b0, 5'd0, 32'h0);
    set_ll(1'b0, 5'd0, 32'h0);
    #1;
    check("t4b_cnt1", fifo_cnt_o, 1);
    check("t4b_killed_we", rf_we_o, 0);
    next_cyc(); #1;
    check("t4b_cnt0", fifo_cnt_o, 0);
    check("t4b_x4", rf_model[4], 32'h22);

    // 5. Back-pressure: five pushes into a four-entry FIFO under a busy pipe.
    log_en = 1'b1;
    i = 0;
    for (int c = 0; c < 150 && ll_log.size() < 5; c++) begin
      next_cyc();
      set_pipe(i < 5, 5'd3, 32'h33);
      set_ll(i < 5, 5'(10 + i), 32'h100 + i);
      #1;
      rdy = ll_ready_o;
      if (c == 3) check("t5_ready_c3", rdy, 1);
      if (c == 4) check("t5_ready_full", rdy, 0);
      if (c == 9) check("t5_ready_popfull", rdy, 0);
      if (c == 10) check("t5_ready_c10", rdy, 1);
      if (rdy && i < 5) i++;
    end
    set_ll(1'b0, 5'd0, 32'h0);
    set_pipe(1'b0, 5'd0, 32'h0);
    log_en = 1'b0;
    check("t5_count", ll_log.size(), 5);
    for (int k = 0; k < 5 && k < ll_log.size(); k++)
      check($sformatf("t5_order%0d", k), ll_log[k], 10 + k);
    check("t5_x14", rf_model[14], 32'h104);
    next_cyc(); next_cyc();

    // 6. Reset during FORCE with three entries queued.
    for (int k = 0; k <= 9; k++) begin
      next_cyc();
      set_pipe(1'b1, 5'd3, 32'h33);
      if (k < 3) set_ll(1'b1, 5'(20 + k), 32'h200 + k);
      else set_ll(1'b0, 5'd0, 32'h0);
    end
    #1;
    check("t6_force", stall_o, 1);
    check("t6_cnt3", fifo_cnt_o, 3);
    #1;
    reset = 1'b0;
    #1;
    check("t6_rst_we", rf_we_o, 0);
    check("t6_rst_stall", stall_o, 0);
    check("t6_rst_ready", ll_ready_o, 0);
    check("t6_rst_cnt", fifo_cnt_o, 0);
    next_cyc();
    reset = 1'b1;
    set_pipe(1'b0, 5'd0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      next_cyc(); #1;
      check("t6_post_cnt", fifo_cnt_o, 0);
      check("t6_post_we", rf_we_o, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
